// File: rtl/control_sequencer_pkg.sv
// cpu_ctrl_pkg: opcodes, ALU codes, step encodings and the strobe bundle
// shared by the control_sequencer slice.
package cpu_ctrl_pkg;

    localparam int OPW    = 5;
    localparam int STEP_W = 4;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_BR   = 5'b10011;
    localparam logic [OPW-1:0] OP_JR   = 5'b10100;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    localparam logic [OPW-1:0] ALU_ADD = 5'b00011;

    typedef enum logic [STEP_W-1:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } step_t;

    typedef struct packed {
        logic           pc_out;
        logic           zlow_out;
        logic           zhigh_out;
        logic           mdr_out;
        logic           hi_out;
        logic           lo_out;
        logic           c_out;
        logic           inport_out;
        logic           mar_in;
        logic           z_in;
        logic           pc_in;
        logic           mdr_in;
        logic           ir_in;
        logic           y_in;
        logic           con_in;
        logic           inc_pc;
        logic           read;
        logic           write;
        logic           gra;
        logic           grb;
        logic           grc;
        logic           r_in;
        logic           r_out;
        logic           ba_out;
        logic [OPW-1:0] operation;
    } strobes_t;

    // Final execute step of each instruction; undefined opcodes end at T3 like nop.
    function automatic step_t last_step(input logic [OPW-1:0] op);
        step_t s;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: s = S_T5;
            OP_BR:                                  s = S_T6;
            OP_LD, OP_ST:                           s = S_T7;
            OP_JR, OP_NOP:                          s = S_T3;
            default:                                s = S_T3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: datapath feedback into the sequencer and the strobes
// it drives back. master = sequencer, slave = datapath.
// Mem_ready exists only when MEM_WAIT_EN is defined.
interface control_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic [OPW-1:0] Opcode;
    logic           CON_out;
    logic           Stop;
`ifdef MEM_WAIT_EN
    logic           Mem_ready;
`endif

    logic PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, CON_in;
    logic IncPC, Read, Write;
    logic GRA, GRB, GRC, Rin, Rout, BAout;
    logic [OPW-1:0] operation;
    logic Run;

    modport master (
        input  Opcode, CON_out, Stop,
`ifdef MEM_WAIT_EN
        input  Mem_ready,
`endif
        output PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, CON_in,
        output IncPC, Read, Write,
        output GRA, GRB, GRC, Rin, Rout, BAout,
        output operation, Run
    );

    modport slave (
        output Opcode, CON_out, Stop,
`ifdef MEM_WAIT_EN
        output Mem_ready,
`endif
        input  PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, CON_in,
        input  IncPC, Read, Write,
        input  GRA, GRB, GRC, Rin, Rout, BAout,
        input  operation, Run
    );

endinterface

// File: rtl/control_sequencer_step_decoder.sv
// ctrl_step_decoder: pure combinational map from (step, opcode, CON_out) to
// the datapath strobe bundle. Opcode is only meaningful from T3 on.
module ctrl_step_decoder
    import cpu_ctrl_pkg::*;
(
    input  step_t          state,
    input  logic [OPW-1:0] opcode,
    input  logic           con_out,
    output strobes_t       strobes
);

    // Decode the current step; every strobe not named below stays 0.
    always_comb begin
        strobes = '0;
        case (state)
            S_T0: begin
                strobes.pc_out = 1'b1; strobes.mar_in = 1'b1;
                strobes.inc_pc = 1'b1; strobes.z_in   = 1'b1;
            end
            S_T1: begin
                strobes.zlow_out = 1'b1; strobes.pc_in  = 1'b1;
                strobes.read     = 1'b1; strobes.mdr_in = 1'b1;
            end
            S_T2: begin
                strobes.mdr_out = 1'b1; strobes.ir_in = 1'b1;
            end
            S_T3: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.y_in = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        strobes.grb = 1'b1; strobes.ba_out = 1'b1; strobes.y_in = 1'b1;
                    end
                    OP_JR: begin
                        strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.pc_in = 1'b1;
                    end
                    OP_BR: begin
                        strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.con_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        strobes.grc = 1'b1; strobes.r_out = 1'b1; strobes.z_in = 1'b1;
                        strobes.operation = opcode;
                    end
                    OP_ADDI, OP_LD, OP_ST: begin
                        strobes.c_out = 1'b1; strobes.z_in = 1'b1;
                        strobes.operation = ALU_ADD;
                    end
                    OP_BR: begin
                        strobes.pc_out = 1'b1; strobes.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        strobes.zlow_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        strobes.zlow_out = 1'b1; strobes.mar_in = 1'b1;
                    end
                    OP_BR: begin
                        strobes.c_out = 1'b1; strobes.z_in = 1'b1;
                        strobes.operation = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (opcode)
                    OP_LD: begin
                        strobes.read = 1'b1; strobes.mdr_in = 1'b1;
                    end
                    OP_ST: begin
                        // Read stays 0 so MDR loads from the bus, not memory.
                        strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.mdr_in = 1'b1;
                    end
                    OP_BR: begin
                        strobes.zlow_out = 1'b1; strobes.pc_in = con_out;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (opcode)
                    OP_LD: begin
                        strobes.mdr_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
                    end
                    OP_ST:   strobes.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit. Holds the step register
// and next-step logic; strobes come from ctrl_step_decoder.
// Optional MEM_WAIT_EN: adds Mem_ready and stretches T1, ld-T6 and st-T7
// while memory is not ready.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                Clock,
    input  logic                Resetn,
    control_sequencer_if.master bus,
    output step_t               dbg_state
);

    step_t    state;
    step_t    next_state;
    strobes_t strobes;
    logic     final_step;
    logic     mem_hold;

    assign final_step = (state == last_step(bus.Opcode));
    assign dbg_state  = state;

`ifdef MEM_WAIT_EN
    assign mem_hold = !bus.Mem_ready &&
                      ((state == S_T1) ||
                       (state == S_T6 && bus.Opcode == OP_LD) ||
                       (state == S_T7 && bus.Opcode == OP_ST));
`else
    assign mem_hold = 1'b0;
`endif

    // State register; reset aborts any step (including a memory hold) at once.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= S_RST;
        else         state <= next_state;
    end

    // Next step: walk T0..T7, leave at the instruction's last step, honour halt/Stop and holds.
    always_comb begin
        next_state = state;
        case (state)
            S_RST:   next_state = S_T0;
            S_T0:    next_state = S_T1;
            S_T1:    next_state = S_T2;
            S_T2:    next_state = S_T3;
            S_T3:    next_state = S_T4;
            S_T4:    next_state = S_T5;
            S_T5:    next_state = S_T6;
            S_T6:    next_state = S_T7;
            S_T7:    next_state = S_T0;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_RST;
        endcase
        if (final_step)                            next_state = bus.Stop ? S_HALT : S_T0;
        if (state == S_T3 && bus.Opcode == OP_HALT) next_state = S_HALT;
        if (mem_hold)                              next_state = state;
    end

    ctrl_step_decoder u_decoder (
        .state   (state),
        .opcode  (bus.Opcode),
        .con_out (bus.CON_out),
        .strobes (strobes)
    );

    // Output map: decoded strobes onto the interface, Run low only in HALT.
    always_comb begin
        bus.PCout     = strobes.pc_out;
        bus.Zlowout   = strobes.zlow_out;
        bus.ZHighout  = strobes.zhigh_out;
        bus.MDRout    = strobes.mdr_out;
        bus.HIout     = strobes.hi_out;
        bus.LOout     = strobes.lo_out;
        bus.Cout      = strobes.c_out;
        bus.InPortout = strobes.inport_out;
        bus.MARin     = strobes.mar_in;
        bus.Zin       = strobes.z_in;
        bus.PCin      = strobes.pc_in;
        bus.MDRin     = strobes.mdr_in;
        bus.IRin      = strobes.ir_in;
        bus.Yin       = strobes.y_in;
        bus.CON_in    = strobes.con_in;
        bus.IncPC     = strobes.inc_pc;
        bus.Read      = strobes.read;
        bus.Write     = strobes.write;
        bus.GRA       = strobes.gra;
        bus.GRB       = strobes.grb;
        bus.GRC       = strobes.grc;
        bus.Rin       = strobes.r_in;
        bus.Rout      = strobes.r_out;
        bus.BAout     = strobes.ba_out;
        bus.operation = strobes.operation;
        bus.Run       = (state != S_HALT);
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized instruction streams against an
// instruction-level model of the control unit, plus directed pins.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    // Bit positions of the flattened output word used by model and compare.
    localparam logic [31:0] M_PCOUT  = 32'd1 << 0;
    localparam logic [31:0] M_ZLOW   = 32'd1 << 1;
    localparam logic [31:0] M_MDROUT = 32'd1 << 3;
    localparam logic [31:0] M_COUT   = 32'd1 << 6;
    localparam logic [31:0] M_MARIN  = 32'd1 << 8;
    localparam logic [31:0] M_ZIN    = 32'd1 << 9;
    localparam logic [31:0] M_PCIN   = 32'd1 << 10;
    localparam logic [31:0] M_MDRIN  = 32'd1 << 11;
    localparam logic [31:0] M_IRIN   = 32'd1 << 12;
    localparam logic [31:0] M_YIN    = 32'd1 << 13;
    localparam logic [31:0] M_CONIN  = 32'd1 << 14;
    localparam logic [31:0] M_INCPC  = 32'd1 << 15;
    localparam logic [31:0] M_READ   = 32'd1 << 16;
    localparam logic [31:0] M_WRITE  = 32'd1 << 17;
    localparam logic [31:0] M_GRA    = 32'd1 << 18;
    localparam logic [31:0] M_GRB    = 32'd1 << 19;
    localparam logic [31:0] M_GRC    = 32'd1 << 20;
    localparam logic [31:0] M_RIN    = 32'd1 << 21;
    localparam logic [31:0] M_ROUT   = 32'd1 << 22;
    localparam logic [31:0] M_BAOUT  = 32'd1 << 23;
    localparam logic [31:0] M_RUN    = 32'd1 << 31;
    localparam logic [31:0] RST_W    = M_RUN;
    localparam logic [31:0] HALT_W   = 32'd0;

    localparam logic [4:0] C_LD = 5'b00000, C_ST = 5'b00010, C_ADD = 5'b00011;
    localparam logic [4:0] C_SUB = 5'b00100, C_AND = 5'b00101, C_OR = 5'b00110;
    localparam logic [4:0] C_ADDI = 5'b01100, C_BR = 5'b10011, C_JR = 5'b10100;
    localparam logic [4:0] C_NOP = 5'b11010, C_HALT = 5'b11011;

    logic  Clock = 1'b0;
    logic  Resetn = 1'b1;
    step_t dbg_state;
    logic [31:0] exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic [4:0] op_tab [10];

    control_sequencer_if bus();

    control_sequencer dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and reset block: 10-unit period, reset driven by tasks below.
    always #5 Clock = ~Clock;

    function automatic logic [31:0] opf(input logic [4:0] op);
        return {3'b000, op, 24'h0};
    endfunction

    function automatic logic [31:0] dut_word();
        logic [31:0] w;
        w = '0;
        w[0]  = bus.PCout;  w[1]  = bus.Zlowout; w[2]  = bus.ZHighout; w[3]  = bus.MDRout;
        w[4]  = bus.HIout;  w[5]  = bus.LOout;   w[6]  = bus.Cout;     w[7]  = bus.InPortout;
        w[8]  = bus.MARin;  w[9]  = bus.Zin;     w[10] = bus.PCin;     w[11] = bus.MDRin;
        w[12] = bus.IRin;   w[13] = bus.Yin;     w[14] = bus.CON_in;   w[15] = bus.IncPC;
        w[16] = bus.Read;   w[17] = bus.Write;   w[18] = bus.GRA;      w[19] = bus.GRB;
        w[20] = bus.GRC;    w[21] = bus.Rin;     w[22] = bus.Rout;     w[23] = bus.BAout;
        w[28:24] = bus.operation;
        w[31] = bus.Run;
        return w;
    endfunction

    // Number of cycles from T0 to the instruction's last step inclusive.
    function automatic int instr_len(input logic [4:0] op);
        if (op inside {C_ADD, C_SUB, C_AND, C_OR, C_ADDI}) return 6;
        if (op == C_BR)                                    return 7;
        if (op inside {C_LD, C_ST})                        return 8;
        return 4;
    endfunction

    // Steps that may be stretched by memory wait states.
    function automatic bit hold_step(input logic [4:0] op, input int k);
`ifdef MEM_WAIT_EN
        return (k == 1) || (op == C_LD && k == 6) || (op == C_ST && k == 7);
`else
        return (op == 5'd0 && k < 0);
`endif
    endfunction

    // Instruction-level model: what step k of instruction op must drive.
    function automatic logic [31:0] model_word(input logic [4:0] op, input int k, input logic con);
        logic [31:0] w;
        w = M_RUN;
        if (k == 0)      w |= M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
        else if (k == 1) w |= M_ZLOW | M_PCIN | M_READ | M_MDRIN;
        else if (k == 2) w |= M_MDROUT | M_IRIN;
        else if (op inside {C_ADD, C_SUB, C_AND, C_OR}) begin
            if (k == 3) w |= M_GRB | M_ROUT | M_YIN;
            if (k == 4) w |= M_GRC | M_ROUT | M_ZIN | opf(op);
            if (k == 5) w |= M_ZLOW | M_GRA | M_RIN;
        end else if (op == C_ADDI) begin
            if (k == 3) w |= M_GRB | M_ROUT | M_YIN;
            if (k == 4) w |= M_COUT | M_ZIN | opf(C_ADD);
            if (k == 5) w |= M_ZLOW | M_GRA | M_RIN;
        end else if (op == C_LD || op == C_ST) begin
            if (k == 3) w |= M_GRB | M_BAOUT | M_YIN;
            if (k == 4) w |= M_COUT | M_ZIN | opf(C_ADD);
            if (k == 5) w |= M_ZLOW | M_MARIN;
            if (k == 6) w |= (op == C_LD) ? (M_READ | M_MDRIN) : (M_GRA | M_ROUT | M_MDRIN);
            if (k == 7) w |= (op == C_LD) ? (M_MDROUT | M_GRA | M_RIN) : M_WRITE;
        end else if (op == C_JR) begin
            if (k == 3) w |= M_GRA | M_ROUT | M_PCIN;
        end else if (op == C_BR) begin
            if (k == 3) w |= M_GRA | M_ROUT | M_CONIN;
            if (k == 4) w |= M_PCOUT | M_YIN;
            if (k == 5) w |= M_COUT | M_ZIN | opf(C_ADD);
            if (k == 6) w |= M_ZLOW | (con ? M_PCIN : 32'd0);
        end
        return w;
    endfunction

    // Scoreboard: one expected word per cycle, checked mid-cycle.
    always @(negedge Clock) begin : compare
        logic [31:0] e;
        logic [31:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = dut_word();
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL cycle_word t=%0t state=%0d actual=%h required=%h", $time, dbg_state, a, e);
            end
            n_cmp++;
            if ((bus.Read & bus.Write) !== 1'b0) begin
                n_bad++;
                $display("FAIL read_write_excl t=%0t actual=1 required=0", $time);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    task automatic rand_inputs();
        bus.Opcode  = 5'($urandom_range(0, 31));
        bus.CON_out = 1'($urandom_range(0, 1));
        bus.Stop    = 1'($urandom_range(0, 1));
`ifdef MEM_WAIT_EN
        bus.Mem_ready = 1'($urandom_range(0, 1));
`endif
    endtask

    // Called at posedge+1: reset for two cycles, released before the next edge.
    task automatic do_reset();
        Resetn = 1'b0;
        rand_inputs();
        #1 check_lit("reset_async", dut_word(), RST_W);
        exp_q.push_back(RST_W);
        @(posedge Clock); #1;
        rand_inputs();
        exp_q.push_back(RST_W);
        #2 Resetn = 1'b1;
    endtask

    // HALT for 20 cycles with random inputs, then a reset pulse.
    task automatic halt_phase();
        for (int i = 0; i < 20; i++) begin
            @(posedge Clock); #1;
            rand_inputs();
            exp_q.push_back(HALT_W);
            if (i == 0 || i == 19) begin
                #1 check_lit("halt_run", {31'd0, bus.Run}, 32'd0);
            end
        end
        @(posedge Clock); #1;
        do_reset();
    endtask

    // Driver: one instruction from T0; optional abort, forced CON at last step,
    // forced wait count, and a literal pin at step pin_k.
    task automatic run_instr(input logic [4:0] op, input bit stop_last, input int abort_k,
                             input int con_last, input int nwait,
                             input string pin_name, input int pin_k, input logic [31:0] pin_w);
        int n;
        int hold;
        n = instr_len(op);
        for (int k = 0; k < n; k++) begin
            hold = 0;
            if (hold_step(op, k)) hold = (nwait >= 0) ? nwait : int'($urandom_range(0, 2));
            for (int w = 0; w <= hold; w++) begin
                @(posedge Clock); #1;
                if (k == abort_k) begin
                    do_reset();
                    return;
                end
                bus.Opcode  = (k < 3) ? 5'($urandom_range(0, 31)) : op;
                bus.CON_out = (k == n - 1 && con_last >= 0) ? con_last[0] : 1'($urandom_range(0, 1));
                bus.Stop    = (k == n - 1) ? stop_last : 1'($urandom_range(0, 1));
`ifdef MEM_WAIT_EN
                bus.Mem_ready = hold_step(op, k) ? (w == hold) : 1'($urandom_range(0, 1));
`endif
                exp_q.push_back(model_word(op, k, bus.CON_out));
                if (k == pin_k && w == 0) begin
                    #1 check_lit(pin_name, dut_word(), pin_w);
                end
            end
        end
        if (op == C_HALT || stop_last) halt_phase();
    endtask

    // Stimulus: directed cases first, then a random instruction stream.
    initial begin : stimulus
        int n;
        logic [4:0] op;
        op_tab = '{C_LD, C_ST, C_ADD, C_SUB, C_AND, C_OR, C_ADDI, C_BR, C_JR, C_NOP};
        rand_inputs();
        @(posedge Clock); #1;
        do_reset();

        run_instr(C_ADD, 1'b0, -1, -1, -1, "t0_after_reset", 0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN);
        run_instr(C_ADD, 1'b0, -1, -1, -1, "add_t4", 4, M_GRC | M_ROUT | M_ZIN | {3'b000, 5'b00011, 24'h0} | M_RUN);
        run_instr(C_ADD, 1'b0, 4, -1, -1, "", -1, 32'd0);
        run_instr(C_ADD, 1'b0, -1, -1, -1, "t0_after_abort", 0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN);
        run_instr(C_JR, 1'b0, -1, -1, -1, "jr_t3", 3, M_GRA | M_ROUT | M_PCIN | M_RUN);
        run_instr(C_ADD, 1'b0, -1, -1, -1, "t0_after_jr", 0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN);
        run_instr(C_BR, 1'b0, -1, 1, -1, "br_t6_taken", 6, M_ZLOW | M_PCIN | M_RUN);
        run_instr(C_BR, 1'b0, -1, 0, -1, "br_t6_not_taken", 6, M_ZLOW | M_RUN);
        run_instr(C_ST, 1'b0, -1, -1, 3, "st_t7", 7, M_WRITE | M_RUN);
        run_instr(C_LD, 1'b0, -1, -1, -1, "ld_t6", 6, M_READ | M_MDRIN | M_RUN);
        run_instr(5'b01111, 1'b0, -1, -1, -1, "undef_t3", 3, M_RUN);
        run_instr(C_HALT, 1'b0, -1, -1, -1, "halt_t3", 3, M_RUN);
        run_instr(C_ADDI, 1'b1, -1, -1, -1, "addi_t5", 5, M_ZLOW | M_GRA | M_RIN | M_RUN);

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(0, 31));
            else                           op = op_tab[$urandom_range(0, 9)];
            n = instr_len(op);
            run_instr(op, ($urandom_range(0, 15) == 0),
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, n - 1)) : -1,
                      -1, -1, "", -1, 32'd0);
        end

        @(posedge Clock); #1;
        rand_inputs();
        @(negedge Clock); #1;
        check_lit("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit for the 32-bit bus CPU.
- Generates the per-step datapath strobes (PCout, MARin, IncPC, Read, MDRin, IRin, GRA/GRB/GRC, Rin/Rout, etc.) that the datapath consumes.
- Steps through fetch (T0-T2), then an opcode-dependent execute sequence (T3-T7), then returns to T0.
- Sits beside the datapath; its only feedback is the opcode field IR[31:27], CON_out and Stop.

Parameters:
- OPW, 5, opcode/ALU operation width.
- STEP_W, 4, state encoding width.

Ports:
- Clock  in  1  single system clock; all state updates on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Opcode  in  5  IR[31:27] from datapath IR.
- CON_out  in  1  branch condition result from the CON FF.
- Stop  in  1  halt request, sampled at the final step of each instruction.
- PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout  out  1 each  bus drive strobes.
- MARin, Zin, PCin, MDRin, IRin, Yin, CON_in  out  1 each  register load strobes.
- IncPC, Read, Write  out  1 each  PC-increment select and memory strobes.
- GRA, GRB, GRC, Rin, Rout, BAout  out  1 each  register-select controls.
- operation  out  5  ALU operation code.
- Run  out  1  1 while executing, 0 in HALT.

Behaviour:
- Reset: asynchronous, active-low. State = RST. All strobes 0, operation = 0, Run = 1.
- Deassertion: RST -> T0 on the next rising edge. Reset mid-instruction aborts at once; no partial Write may follow.
- Outputs are a pure function of the state register and the current Opcode/CON_out (Moore plus opcode decode). No glitch-free guarantee is required.
- Each state lasts exactly 1 clock unless MEM_WAIT_EN applies.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - Opcode is decoded from T3 onward, since IR loads at the end of T2.
- add/sub/and/or (00011/00100/00101/00110):
  - T3: GRB, Rout, Yin.
  - T4: GRC, Rout, Zin, operation = Opcode.
  - T5: Zlowout, GRA, Rin.
- addi (01100):
  - T3: GRB, Rout, Yin.
  - T4: Cout, Zin, operation = ADD.
  - T5: Zlowout, GRA, Rin.
- ld (00000):
  - T3: GRB, BAout, Yin.
  - T4: Cout, Zin, operation = ADD.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, GRA, Rin.
- st (00010):
  - T3-T5 as ld.
  - T6: GRA, Rout, MDRin (Read = 0).
  - T7: Write.
- jr (10100):
  - T3: GRA, Rout, PCin.
- br (10011):
  - T3: GRA, Rout, CON_in.
  - T4: PCout, Yin.
  - T5: Cout, Zin, operation = ADD.
  - T6: Zlowout, plus PCin only if CON_out = 1.
- nop (11010) and any undefined opcode: T3 with all strobes 0.
- halt (11011): T3 -> HALT. In HALT all strobes are 0 and Run = 0 until reset.
- Last step of an instruction: next state = T0, or HALT if Stop = 1 in that cycle.
- Stop is ignored in all other steps.
- Read and Write are never both 1. MDRin with Read = 0 selects the bus.
- Unused strobes are 0 in every state.

Optional Feature:
- Macro: MEM_WAIT_EN.
- When defined:
  - Adds input port Mem_ready (1 bit).
  - T1 and ld-T6 hold (state unchanged, strobes held) while Mem_ready = 0.
  - st-T7 holds Write while Mem_ready = 0.
  - Reset while holding aborts the hold.
- When undefined:
  - No port.
  - Memory is assumed single-cycle; every state lasts 1 clock.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (LD, ST, ADD, SUB, AND, OR, ADDI, BR, JR, NOP, HALT);
  - ALU op code ADD = 00011;
  - state encodings RST, T0-T7, HALT.
- One sub-module, ctrl_step_decoder: combinational map (state, Opcode, CON_out) -> strobe vector.
- The top level keeps the state register and next-state logic.

Test Plan:
- Reset low for 2 cycles mid-T4 of add -> all strobes 0 immediately; after release, T0 asserts PCout = MARin = IncPC = Zin = 1.
- Opcode = 00011 (add) -> T3 Yin+GRB+Rout; T4 operation = 00011, Zin; T5 GRA+Rin; next cycle back to T0. Total 6 cycles.
- Opcode = 10100 (jr) -> T3 GRA = Rout = PCin = 1 for exactly one cycle, then T0 (4 cycles total).
- Opcode = 10011 (br):
  - with CON_out = 1, T6 asserts Zlowout and PCin;
  - with CON_out = 0, T6 asserts Zlowout only.
- Opcode = 00010 (st) -> Write = 1 only in T7, never with Read. With MEM_WAIT_EN and Mem_ready = 0 for 3 cycles, Write is held for 4 cycles.
- Opcode = 11011 (halt), or Stop = 1 at T5 of addi -> HALT with Run = 0; stays there for 20 cycles until Resetn pulses.
